hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that drives the stall, bubble and flush controls for the IF/ID, ID/EX and EX/MEM registers of the 5-stage MIPS pipeline. It consumes ID-stage source fields, EX-stage load and branch status, and the data-memory busy signal. It produces the write enables and kill signals those registers obey. It also defers branch flushes across memory waits, flags memory timeouts and counts stall cycles.

## Interface

Parameters:
- TIMEOUT, 16, number of consecutive dmem_busy cycles after which mem_timeout is raised (≥1)
- CNT_W, 16, width of stall_cnt

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination (rt) of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads zero WB/M/EX control fields
- exmem_hold  out  1  EX/MEM and MEM/WB hold their contents
- mem_timeout  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0
- hz_state  out  2  current FSM state (debug)

## Operation

- FSM states: RUN=0, MWAIT=1 (memory wait), MWAIT_F=2 (memory wait with flush pending). Code 3 is unused and is treated as RUN.
- Per-cycle action, highest priority first. Outputs are combinational from state and inputs.
  1. rst=1: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0. Next state RUN. mem_timeout, stall_cnt and wait counter are cleared. Any pending flush is discarded.
  2. FREEZE (dmem_busy=1): pc_write=0, ifid_write=0, idex_write=0, exmem_hold=1, ifid_flush=0, idex_bubble=0.
     - Next state is MWAIT_F if ex_branch_taken=1 or the current state is MWAIT_F.
     - Otherwise next state is MWAIT.
  3. FLUSH (dmem_busy=0 and (ex_branch_taken=1 or state=MWAIT_F)): pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_hold=0. Next state RUN.
  4. LOAD-USE stall: applies when all of the following hold:
     - dmem_busy=0 and no FLUSH this cycle;
     - ex_mem_read=1 and ex_rt≠0;
     - ex_rt==id_rs, or (id_uses_rt=1 and ex_rt==id_rt).
     Outputs: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=0, exmem_hold=0. Next state RUN.
  5. NORMAL: pc_write=1, ifid_write=1, idex_write=1, all other controls 0. Next state RUN.
- Wait counter (width $clog2(TIMEOUT+1)):
  - Increments on each FREEZE cycle and saturates at TIMEOUT.
  - Clears on any non-FREEZE cycle.
- mem_timeout is set on the edge that ends a FREEZE cycle in which the wait counter already equals TIMEOUT−1, i.e. after the TIMEOUT-th consecutive busy cycle. It stays at 1 until rst; busy deasserting does not clear it.
- stall_cnt:
  - Increments at each edge where the cycle had pc_write=0 and rst=0.
  - Saturates at all-ones.
  - Reset cycles are not counted.

## Timing

- Zero-cycle latency: controls respond in the same cycle as the inputs.
- Latency of registered state: hz_state, mem_timeout and stall_cnt update one edge after the causing cycle.
- A taken branch seen during FREEZE is never lost. It is applied on the first cycle with dmem_busy=0, even if ex_branch_taken has since dropped.
- Simultaneous branch and load-use: FLUSH wins; the load-use stall is suppressed.
- Simultaneous busy and load-use: FREEZE wins. The load-use stall is re-evaluated when busy drops.
- A single load-use stall lasts exactly one cycle, because the bubble removes the load from EX.
- Reset values: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, mem_timeout=0, stall_cnt=0, hz_state=0.

## Structure

- Shared package hz_pkg holds:
  - state enum (RUN, MWAIT, MWAIT_F);
  - REG_ADDR_W=5 and the zero-register constant;
  - a control-bundle struct {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold}.
- One sub-module, hz_load_use: purely combinational register-field comparator producing load_use_hit. All other logic (FSM, counters, output mux) lives in hazard_ctrl.

## Test plan

- Reset, then idle: rst=1 for 2 cycles → outputs equal the reset values. After release with all inputs 0 → pc_write=ifid_write=idex_write=1, stall_cnt=0.
- Load-use hit: ex_mem_read=1, ex_rt=5, id_rs=5 → one cycle of pc_write=0, idex_bubble=1; stall_cnt=1. Repeat with ex_rt=0 → no stall. Repeat with id_rt=5, id_uses_rt=0 → no stall.
- Branch flush: ex_branch_taken=1 for 1 cycle → ifid_flush=idex_bubble=1, pc_write=1; next cycle NORMAL.
- Deferred flush: dmem_busy=1 for 3 cycles with ex_branch_taken=1 in cycle 1 only:
  - cycles 1-3 show FREEZE, with hz_state=2 from cycle 2;
  - cycle 4 (busy=0) shows FLUSH;
  - stall_cnt=3.
- Timeout: TIMEOUT=4 with dmem_busy=1 for 4 cycles → mem_timeout=1 from cycle 5 and stays 1 after busy drops. With busy=1 for only 3 cycles → mem_timeout stays 0.
- Reset mid-MWAIT_F: branch taken during busy, rst asserted next cycle, then busy=0 → no FLUSH after reset release; hz_state=0.

Source files
------------

// File: rtl/hz_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, register-field constants and the control bundle.
package hz_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MWAIT   = 2'd1,
        MWAIT_F = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_hold;
    } hz_ctrl_t;

    // Field order: pc_write, ifid_write, ifid_flush,
    // idex_write, idex_bubble, exmem_hold
    localparam hz_ctrl_t CTRL_RESET =
        '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE =
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_FLUSH =
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_STALL =
        '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_NORMAL =
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/hz_load_use.sv
// Load-use comparator: flags an ID source that matches a load's
// destination in EX. Ports: ID rs/rt/uses_rt, EX mem_read/rt, hit out.
module hz_load_use
    import hz_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  load_use_hit
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt && (ex_rt == id_rt);

    // A load into $zero never produces a real dependency.
    assign load_use_hit = ex_mem_read && (ex_rt != REG_ZERO)
                          && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/bubble/flush/hold for IF/ID, ID/EX, EX/MEM,
// deferred branch flush across memory waits, timeout flag, stall counter.
// Ports: clk, rst (sync, high), ID/EX hazard fields, dmem_busy in;
// pipeline register controls, mem_timeout, stall_cnt, hz_state out.
module hazard_ctrl
    import hz_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_busy,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_write,
    output logic                  idex_bubble,
    output logic                  exmem_hold,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [1:0]            hz_state
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    hz_state_e         state_q;
    hz_state_e         state_d;
    hz_ctrl_t          ctrl;
    logic              load_use_hit;
    logic              flush_pend;
    logic              freeze;
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_q;

    hz_load_use u_load_use (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .load_use_hit(load_use_hit)
    );

    // Unused code 3 falls out as "no flush pending", i.e. RUN.
    assign flush_pend = (state_q == MWAIT_F);
    assign freeze     = !rst && dmem_busy;

    always_comb begin
        ctrl    = CTRL_NORMAL;
        state_d = RUN;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (dmem_busy) begin
            ctrl = CTRL_FREEZE;
            // Remember a taken branch until memory lets go.
            if (ex_branch_taken || flush_pend)
                state_d = MWAIT_F;
            else
                state_d = MWAIT;
        end else if (ex_branch_taken || flush_pend) begin
            ctrl = CTRL_FLUSH;
        end else if (load_use_hit) begin
            ctrl = CTRL_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q <= state_d;
            if (freeze) begin
                if (wait_q != WAIT_MAX)
                    wait_q <= wait_q + 1'b1;
                if (wait_q == WAIT_LAST)
                    timeout_q <= 1'b1;
            end else begin
                wait_q <= '0;
            end
            if (!ctrl.pc_write && (stall_q != {CNT_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_write  = ctrl.idex_write;
    assign idex_bubble = ctrl.idex_bubble;
    assign exmem_hold  = ctrl.exmem_hold;
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_q;
    assign hz_state    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed plan plus random traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_mem_read;
    logic          ex_branch_taken, dmem_busy;
    logic          pc_write, ifid_write, ifid_flush;
    logic          idex_write, idex_bubble, exmem_hold;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt;
    logic [1:0]    hz_state;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    int   m_run;
    bit   m_pend;
    int   m_stall;
    bit   m_to;
    logic [1:0] m_state;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .dmem_busy      (dmem_busy),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_write     (idex_write),
        .idex_bubble    (idex_bubble),
        .exmem_hold     (exmem_hold),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt),
        .hz_state       (hz_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after negedge, check before posedge,
    // then advance the model across the edge.
    task automatic cy(input bit r, input bit busy, input bit br,
                      input bit mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input bit urt);
        logic [5:0] e;
        logic [5:0] o;
        bit hit;
        rst = r; dmem_busy = busy; ex_branch_taken = br;
        ex_mem_read = mr; ex_rt = ert; id_rs = rs;
        id_rt = rt; id_uses_rt = urt;
        #1;
        hit = mr && (ert != 0) && (ert == rs || (urt && ert == rt));
        if (r)                 e = 6'b001010;
        else if (busy)         e = 6'b000001;
        else if (br || m_pend) e = 6'b111110;
        else if (hit)          e = 6'b000110;
        else                   e = 6'b110100;
        o = {pc_write, ifid_write, ifid_flush,
             idex_write, idex_bubble, exmem_hold};
        chk("ctrl", 32'(o), 32'(e));
        chk("hz_state", 32'(hz_state), 32'(m_state));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        @(posedge clk);
        if (r) begin
            m_run = 0; m_pend = 0; m_stall = 0;
            m_to = 0; m_state = 2'd0;
        end else begin
            if (!e[5] && m_stall < CMAX) m_stall++;
            if (busy) begin
                m_run++;
                if (m_run >= TO) m_to = 1;
                m_pend = m_pend || br;
                m_state = m_pend ? 2'd2 : 2'd1;
            end else begin
                m_run = 0; m_pend = 0; m_state = 2'd0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cy(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; dmem_busy = 0; ex_branch_taken = 0;
        ex_mem_read = 0; ex_rt = 0; id_rs = 0;
        id_rt = 0; id_uses_rt = 0;
        @(posedge clk);
        @(negedge clk);
        m_run = 0; m_pend = 0; m_stall = 0;
        m_to = 0; m_state = 2'd0;

        // reset then idle
        cy(1, 0, 0, 0, 0, 0, 0, 0);
        cy(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use hit, then load gone
        cy(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        idle(1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        // $zero destination and unused rt: no stall
        cy(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        cy(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        cy(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1);
        // branch flush beats load-use
        cy(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
        idle(1);
        // deferred flush
        cy(0, 1, 1, 0, 0, 0, 0, 0);
        cy(0, 1, 0, 0, 0, 0, 0, 0);
        cy(0, 1, 0, 0, 0, 0, 0, 0);
        chk("defer_state", 32'(hz_state), 32'd2);
        cy(0, 0, 0, 0, 0, 0, 0, 0);
        chk("defer_stall_cnt", 32'(stall_cnt), 32'd5);
        idle(1);
        // short wait: no timeout
        for (int i = 0; i < TO - 1; i++) cy(0, 1, 0, 1, 5'd3, 5'd3, 0, 0);
        idle(2);
        chk("no_timeout", 32'(mem_timeout), 32'd0);
        // full wait: timeout sticks
        for (int i = 0; i < TO; i++) cy(0, 1, 0, 0, 0, 0, 0, 0);
        chk("timeout_set", 32'(mem_timeout), 32'd1);
        idle(2);
        chk("timeout_sticky", 32'(mem_timeout), 32'd1);
        // reset while flush pending
        cy(0, 1, 1, 0, 0, 0, 0, 0);
        cy(1, 1, 0, 0, 0, 0, 0, 0);
        cy(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_drop_flush", 32'(hz_state), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int pb;
            pb = ((i / 100) % 2 == 1) ? 75 : 25;
            cy(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 99) < pb),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 2) == 0),
               5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
